// File: rtl/pixel_pkg.sv
// Shared types for the pixel plot path.
//   COORD_W / COLOUR_W : pixel field widths
//   pixel_t            : one renderer pixel {x, y, colour}
//   plot_state_e       : output-stage FSM states of pixel_plot_fifo
package pixel_pkg;
  localparam int COORD_W  = 9;
  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_LOAD   = 2'd1,
    S_ACTIVE = 2'd2
  } plot_state_e;
endpackage

// File: rtl/pixel_sync_fifo.sv
// Single-clock FIFO of pixel_t entries.
//   clock, resetn : clock, async active-low reset (empties the FIFO)
//   push, wr_data : write an entry (ignored when full)
//   pop, rd_data  : rd_data is the head (show-ahead); pop removes it (ignored when empty)
//   full, empty   : occupancy flags decoded from the internal occupancy counter
module pixel_sync_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clock,
  input  logic   resetn,
  input  logic   push,
  input  pixel_t wr_data,
  input  logic   pop,
  output pixel_t rd_data,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  pixel_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [AW:0]   count_d, count_q;
  logic          push_ok, pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/pixel_plot_fifo.sv
// Buffers the renderer's pixel stream and plots it to the VGA adapter.
//   clock, resetn                   : clock, async active-low reset
//   x_in/y_in/colour_in, in_valid   : renderer pixel; dropped (overflow) if in_ready=0
//   in_ready                        : FIFO not full (no path from plot_ready)
//   x_out/y_out/colour_out, plot    : registered output stage, held until popped
//   plot_ready                      : adapter accepts the pixel (pop = plot & plot_ready)
//   frame_done, frame_count         : pulse/count when (MAX_X, MAX_Y) is plotted
//   overflow                        : sticky lost-pixel flag
// Build option PIXEL_PLOT_FIFO_CLIP_EN: off-screen pixels are discarded at the input.
module pixel_plot_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int MAX_X = 319,
  parameter int MAX_Y = 239
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [COORD_W-1:0]  x_in,
  input  logic [COORD_W-1:0]  y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [COORD_W-1:0]  x_out,
  output logic [COORD_W-1:0]  y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  input  logic                plot_ready,
  output logic                frame_done,
  output logic [15:0]         frame_count,
  output logic                overflow
);
  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(MAX_Y);

  plot_state_e state_d, state_q;
  pixel_t      pix_in, fifo_head, out_d, out_q;
  logic        fifo_full, fifo_empty, fifo_pop, load_out;
  logic        in_range, push, drop, pop_out, frame_hit;
  logic        frame_done_d, frame_done_q, overflow_d, overflow_q;
  logic [15:0] frame_count_d, frame_count_q;

  always_comb begin
    pix_in.x      = x_in;
    pix_in.y      = y_in;
    pix_in.colour = colour_in;
  end

`ifdef PIXEL_PLOT_FIFO_CLIP_EN
  assign in_range = (x_in <= LAST_X) && (y_in <= LAST_Y);
`else
  assign in_range = 1'b1;
`endif

  // Clipped pixels are neither pushed nor counted as lost.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready & in_range;
  assign drop     = in_valid & ~in_ready & in_range;
  assign plot     = (state_q == S_ACTIVE);
  assign pop_out  = plot & plot_ready;

  pixel_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push    (push),
    .wr_data (pix_in),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load_out = 1'b0;
    case (state_q)
      S_EMPTY: if (push) state_d = S_LOAD;
      S_LOAD: begin
        // FIFO is never empty here: we only enter LOAD after a push.
        fifo_pop = 1'b1;
        load_out = 1'b1;
        state_d  = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (pop_out) begin
          if (!fifo_empty) begin
            // Load-through keeps a 1 pixel/cycle stream with no bubble.
            fifo_pop = 1'b1;
            load_out = 1'b1;
          end else if (push) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    out_d         = load_out ? fifo_head : out_q;
    frame_hit     = pop_out && (out_q.x == LAST_X) && (out_q.y == LAST_Y);
    frame_done_d  = frame_hit;
    frame_count_d = frame_count_q + 16'(frame_hit);
    overflow_d    = overflow_q | drop;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_EMPTY;
      out_q         <= '{x: '0, y: '0, colour: COLOUR_BLACK};
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_q         <= out_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign x_out       = out_q.x;
  assign y_out       = out_q.y;
  assign colour_out  = out_q.colour;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;
endmodule
